// File: rtl/vga_avt_write_vram_pkg.sv
// vga_avt_write_vram_pkg
// Shared definitions for the host-side text VRAM writer: control-code
// constants, FSM state encoding, VRAM address width and the screen-size
// helper used to derive the number of character cells.
package vga_avt_write_vram_pkg;

  localparam int ADDR_W = 11;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR,
    ST_DONE
  } wr_state_t;

  // Number of character cells on the screen (RES_X_MAX * RES_Y_MAX).
  // The result must fit the 11-bit VRAM address space (<= 2048).
  function automatic int screen_cells(input int res_x, input int res_y);
    return res_x * res_y;
  endfunction

endpackage

// File: rtl/vga_avt_write_vram_if.sv
// vga_avt_write_vram_if
// Host byte handshake plus VRAM write port and status of the writer.
//   i_valid/i_data : host byte offer
//   o_ready        : writer accepts a byte this cycle
//   o_we/o_addr/o_wdata : VRAM write port (linear address)
//   o_cursor       : current linear cursor
//   o_busy         : clear-screen in progress
// master = host/VRAM side, slave = the writer block.
interface vga_avt_write_vram_if;
  import vga_avt_write_vram_pkg::*;

  logic              i_valid;
  logic [7:0]        i_data;
  logic              o_ready;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [7:0]        o_wdata;
  logic [ADDR_W-1:0] o_cursor;
  logic              o_busy;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_we, o_addr, o_wdata, o_cursor, o_busy
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_we, o_addr, o_wdata, o_cursor, o_busy
  );

endinterface

// File: rtl/vga_avt_write_vram_cursor_ctrl.sv
// vga_cursor_ctrl
// Keeps the text cursor as a column plus the linear base address of the
// current row, and applies the wrap rules for single-cycle commands.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   inc, dec     : advance / back up one cell
//   cr, lf       : carriage return / line feed
//   home         : cursor to cell 0
//   cursor       : registered linear cursor, always row_base + col
module vga_cursor_ctrl
  import vga_avt_write_vram_pkg::*;
#(
  parameter logic [7:0] RES_X_MAX = 8'd80,
  parameter logic [7:0] RES_Y_MAX = 8'd25
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              cr,
  input  logic              lf,
  input  logic              home,
  output logic [ADDR_W-1:0] cursor
);

  localparam int CELLS = screen_cells(int'(RES_X_MAX), int'(RES_Y_MAX));
  localparam logic [ADDR_W-1:0] ROW_W = ADDR_W'(RES_X_MAX);
  localparam logic [ADDR_W-1:0] LAST_COL = ROW_W - 11'd1;
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(CELLS - int'(RES_X_MAX));

  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_n;
  logic [ADDR_W-1:0] row_base_n;

  // Next column / row base. The last row is compared before adding a row so
  // no intermediate value ever reaches the full screen size.
  always_comb begin
    col_n      = col;
    row_base_n = row_base;
    if (home) begin
      col_n      = '0;
      row_base_n = '0;
    end else if (inc) begin
      if (col == LAST_COL) begin
        col_n      = '0;
        row_base_n = (row_base == LAST_ROW_BASE) ? '0 : row_base + ROW_W;
      end else begin
        col_n = col + 11'd1;
      end
    end else if (dec) begin
      if (col != '0) begin
        col_n = col - 11'd1;
      end else if (row_base != '0) begin
        col_n      = LAST_COL;
        row_base_n = row_base - ROW_W;
      end
    end else if (cr) begin
      col_n = '0;
    end else if (lf) begin
      row_base_n = (row_base == LAST_ROW_BASE) ? '0 : row_base + ROW_W;
    end
  end

  // The cursor is registered from the same next values so it always equals
  // row_base + col without a combinational adder on the output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col      <= '0;
      row_base <= '0;
      cursor   <= '0;
    end else begin
      col      <= col_n;
      row_base <= row_base_n;
      cursor   <= row_base_n + col_n;
    end
  end

endmodule

// File: rtl/vga_avt_write_vram.sv
// vga_avt_write_vram
// Host-side writer into the text VRAM. Accepts bytes over valid/ready,
// writes printable bytes at the cursor, interprets CR/LF/BS as cursor moves
// and FF as a full clear-screen with FILL_CHAR.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : i_valid/i_data in; o_ready, o_we, o_addr, o_wdata,
//                  o_cursor, o_busy out (all registered)
module vga_avt_write_vram
  import vga_avt_write_vram_pkg::*;
#(
  parameter logic [7:0] RES_X_MAX = 8'd80,
  parameter logic [7:0] RES_Y_MAX = 8'd25,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  vga_avt_write_vram_if.slave  bus
);

  localparam int CELLS = screen_cells(int'(RES_X_MAX), int'(RES_Y_MAX));
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  wr_state_t         state;
  wr_state_t         state_n;
  logic              we_q;
  logic              we_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdata_q;
  logic [7:0]        wdata_n;
  logic              busy_q;
  logic              busy_n;
  logic              ready_q;
  logic              ready_n;
  logic [7:0]        cmd_q;
  logic [7:0]        cmd_n;
  logic              cur_inc;
  logic              cur_dec;
  logic              cur_cr;
  logic              cur_lf;
  logic              cur_home;
  logic [ADDR_W-1:0] cursor;
  logic              accept;

  assign accept = bus.i_valid && ready_q;

  // Handshake / clear FSM. The accepted byte is decoded in the accept cycle
  // so the VRAM write (or the first clear write) appears one cycle later;
  // the cursor command is issued in EXEC so its result shows the cycle
  // after. During a clear, DONE is the cycle presenting the last address
  // and it issues the cursor home.
  always_comb begin
    state_n  = state;
    we_n     = 1'b0;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    busy_n   = 1'b0;
    cmd_n    = cmd_q;
    cur_inc  = 1'b0;
    cur_dec  = 1'b0;
    cur_cr   = 1'b0;
    cur_lf   = 1'b0;
    cur_home = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          cmd_n   = bus.i_data;
          state_n = ST_EXEC;
          if (bus.i_data == CHR_FF) begin
            we_n    = 1'b1;
            addr_n  = '0;
            wdata_n = FILL_CHAR;
            busy_n  = 1'b1;
          end else if (bus.i_data != CHR_BS && bus.i_data != CHR_LF &&
                       bus.i_data != CHR_CR) begin
            we_n    = 1'b1;
            addr_n  = cursor;
            wdata_n = bus.i_data;
          end
        end
      end
      ST_EXEC: begin
        state_n = ST_IDLE;
        case (cmd_q)
          CHR_FF: begin
            we_n    = 1'b1;
            addr_n  = addr_q + 11'd1;
            busy_n  = 1'b1;
            state_n = (addr_q + 11'd1 == LAST_ADDR) ? ST_DONE : ST_CLEAR;
          end
          CHR_CR:  cur_cr  = 1'b1;
          CHR_LF:  cur_lf  = 1'b1;
          CHR_BS:  cur_dec = 1'b1;
          default: cur_inc = 1'b1;
        endcase
      end
      ST_CLEAR: begin
        we_n   = 1'b1;
        addr_n = addr_q + 11'd1;
        busy_n = 1'b1;
        if (addr_q + 11'd1 == LAST_ADDR) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        cur_home = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_IDLE);
  end

  // State and registered outputs; reset wins in every state, aborting a
  // clear in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      cmd_q   <= '0;
    end else begin
      state   <= state_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      busy_q  <= busy_n;
      ready_q <= ready_n;
      cmd_q   <= cmd_n;
    end
  end

  vga_cursor_ctrl #(
    .RES_X_MAX (RES_X_MAX),
    .RES_Y_MAX (RES_Y_MAX)
  ) u_cursor (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .inc    (cur_inc),
    .dec    (cur_dec),
    .cr     (cur_cr),
    .lf     (cur_lf),
    .home   (cur_home),
    .cursor (cursor)
  );

  assign bus.o_ready  = ready_q;
  assign bus.o_we     = we_q;
  assign bus.o_addr   = addr_q;
  assign bus.o_wdata  = wdata_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_cursor = cursor;

endmodule

// File: tb/tb_vga_avt_write_vram.sv
// tb_vga_avt_write_vram
// Directed self-checking bench for the text VRAM writer on an 80x25 screen.
module tb_vga_avt_write_vram;
  import vga_avt_write_vram_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 i_clk = ~i_clk;

  vga_avt_write_vram_if bus();

  vga_avt_write_vram #(
    .RES_X_MAX (8'd80),
    .RES_Y_MAX (8'd25),
    .FILL_CHAR (8'h20)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst       = 1'b1;
    bus.i_valid = 1'b0;
    step();
    step();
    i_rst = 1'b0;
  endtask

  // Offer one byte; returns 1 ns after the accepting edge (cycle T+1).
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    if (bus.o_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got %0b expected 1", bus.o_ready);
    end
    bus.i_valid = 1'b1;
    bus.i_data  = b;
    step();
    bus.i_valid = 1'b0;
  endtask

  // Send a byte and wait until the writer is back in IDLE (T+2).
  task automatic send_settle(input logic [7:0] b);
    send_byte(b);
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %0b expected 1", bus.o_ready); end
    checks++; if (bus.o_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_we: got %0b expected 0", bus.o_we); end
    checks++; if (bus.o_addr !== 11'd0) begin errors++; $display("[TB] FAIL rst_addr: got %0d expected 0", bus.o_addr); end
    checks++; if (bus.o_wdata !== 8'h00) begin errors++; $display("[TB] FAIL rst_wdata: got %0h expected 0", bus.o_wdata); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %0b expected 0", bus.o_busy); end
    checks++; if (bus.o_cursor !== 11'd0) begin errors++; $display("[TB] FAIL rst_cursor: got %0d expected 0", bus.o_cursor); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h41;
    step();
    checks++; if (bus.o_we !== 1'b1 || bus.o_addr !== 11'd0 || bus.o_wdata !== 8'h41) begin errors++; $display("[TB] FAIL b2b_writeA: got we=%0b addr=%0d data=%0h expected we=1 addr=0 data=41", bus.o_we, bus.o_addr, bus.o_wdata); end
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_notready: got %0b expected 0", bus.o_ready); end
    bus.i_data = 8'h42;
    step();
    checks++; if (bus.o_we !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_cursor !== 11'd1) begin errors++; $display("[TB] FAIL b2b_gap: got we=%0b ready=%0b cursor=%0d expected we=0 ready=1 cursor=1", bus.o_we, bus.o_ready, bus.o_cursor); end
    step();
    checks++; if (bus.o_we !== 1'b1 || bus.o_addr !== 11'd1 || bus.o_wdata !== 8'h42) begin errors++; $display("[TB] FAIL b2b_writeB: got we=%0b addr=%0d data=%0h expected we=1 addr=1 data=42", bus.o_we, bus.o_addr, bus.o_wdata); end
    bus.i_valid = 1'b0;
    step();
    checks++; if (bus.o_we !== 1'b0 || bus.o_cursor !== 11'd2) begin errors++; $display("[TB] FAIL b2b_cursor: got we=%0b cursor=%0d expected we=0 cursor=2", bus.o_we, bus.o_cursor); end
  endtask

  task automatic test_row_wrap();
    logic [7:0] b;
    do_reset();
    for (int i = 1; i <= 82; i++) begin
      b = 8'h61 + 8'(i % 26);
      send_byte(b);
      if (i >= 80) begin
        checks++;
        if (bus.o_we !== 1'b1 || bus.o_addr !== 11'(i - 1) || bus.o_wdata !== b) begin
          errors++;
          $display("[TB] FAIL row_write%0d: got we=%0b addr=%0d data=%0h expected we=1 addr=%0d data=%0h", i, bus.o_we, bus.o_addr, bus.o_wdata, i - 1, b);
        end
      end
      step();
    end
    checks++; if (bus.o_cursor !== 11'd82) begin errors++; $display("[TB] FAIL row_cursor: got %0d expected 82", bus.o_cursor); end
    checks++; if (dut.u_cursor.col !== 11'd2) begin errors++; $display("[TB] FAIL row_col: got %0d expected 2", dut.u_cursor.col); end
  endtask

  task automatic test_screen_wrap();
    do_reset();
    repeat (24) send_settle(CHR_LF);
    checks++; if (bus.o_cursor !== 11'd1920) begin errors++; $display("[TB] FAIL scr_lastrow: got %0d expected 1920", bus.o_cursor); end
    repeat (79) send_settle(8'h78);
    checks++; if (bus.o_cursor !== 11'd1999) begin errors++; $display("[TB] FAIL scr_1999: got %0d expected 1999", bus.o_cursor); end
    send_byte(8'h5A);
    checks++; if (bus.o_we !== 1'b1 || bus.o_addr !== 11'd1999 || bus.o_wdata !== 8'h5A) begin errors++; $display("[TB] FAIL scr_writeZ: got we=%0b addr=%0d data=%0h expected we=1 addr=1999 data=5a", bus.o_we, bus.o_addr, bus.o_wdata); end
    step();
    checks++; if (bus.o_cursor !== 11'd0 || bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL scr_wrap: got cursor=%0d ready=%0b expected cursor=0 ready=1", bus.o_cursor, bus.o_ready); end
  endtask

  task automatic test_cr_lf_bs();
    do_reset();
    send_settle(CHR_LF);
    send_settle(CHR_LF);
    repeat (5) send_settle(8'h2E);
    checks++; if (bus.o_cursor !== 11'd165) begin errors++; $display("[TB] FAIL ctl_start: got %0d expected 165", bus.o_cursor); end
    send_byte(CHR_CR);
    checks++; if (bus.o_we !== 1'b0 || bus.o_cursor !== 11'd165) begin errors++; $display("[TB] FAIL ctl_cr_t1: got we=%0b cursor=%0d expected we=0 cursor=165", bus.o_we, bus.o_cursor); end
    step();
    checks++; if (bus.o_cursor !== 11'd160 || bus.o_ready !== 1'b1 || bus.o_we !== 1'b0) begin errors++; $display("[TB] FAIL ctl_cr: got cursor=%0d ready=%0b we=%0b expected 160 1 0", bus.o_cursor, bus.o_ready, bus.o_we); end
    send_byte(CHR_LF);
    checks++; if (bus.o_we !== 1'b0) begin errors++; $display("[TB] FAIL ctl_lf_we: got %0b expected 0", bus.o_we); end
    step();
    checks++; if (bus.o_cursor !== 11'd240) begin errors++; $display("[TB] FAIL ctl_lf: got %0d expected 240", bus.o_cursor); end
    send_byte(CHR_BS);
    checks++; if (bus.o_we !== 1'b0) begin errors++; $display("[TB] FAIL ctl_bs_we: got %0b expected 0", bus.o_we); end
    step();
    checks++; if (bus.o_cursor !== 11'd239) begin errors++; $display("[TB] FAIL ctl_bs: got %0d expected 239", bus.o_cursor); end
    checks++; if (bus.o_addr !== 11'd164 || bus.o_wdata !== 8'h2E) begin errors++; $display("[TB] FAIL ctl_hold: got addr=%0d data=%0h expected addr=164 data=2e", bus.o_addr, bus.o_wdata); end
  endtask

  task automatic test_boundaries();
    do_reset();
    repeat (24) send_settle(CHR_LF);
    repeat (5) send_settle(8'h2D);
    checks++; if (bus.o_cursor !== 11'd1925) begin errors++; $display("[TB] FAIL bnd_1925: got %0d expected 1925", bus.o_cursor); end
    send_settle(CHR_LF);
    checks++; if (bus.o_cursor !== 11'd5) begin errors++; $display("[TB] FAIL bnd_lfwrap: got %0d expected 5", bus.o_cursor); end
    do_reset();
    send_settle(CHR_LF);
    send_settle(CHR_BS);
    checks++; if (bus.o_cursor !== 11'd79) begin errors++; $display("[TB] FAIL bnd_bsrow: got %0d expected 79", bus.o_cursor); end
    do_reset();
    send_byte(CHR_BS);
    checks++; if (bus.o_we !== 1'b0) begin errors++; $display("[TB] FAIL bnd_bs0_we: got %0b expected 0", bus.o_we); end
    step();
    checks++; if (bus.o_cursor !== 11'd0 || bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL bnd_bs0: got cursor=%0d ready=%0b expected 0 1", bus.o_cursor, bus.o_ready); end
  endtask

  task automatic test_clear();
    int bad = 0;
    int first_bad = -1;
    do_reset();
    repeat (3) send_settle(8'h51);
    send_byte(CHR_FF);
    for (int k = 0; k < 2000; k++) begin
      if (bus.o_we !== 1'b1 || bus.o_addr !== 11'(k) || bus.o_wdata !== 8'h20 ||
          bus.o_busy !== 1'b1 || bus.o_ready !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL clr_cells: got %0d bad cycles (first at %0d) expected 0", bad, first_bad); end
    checks++; if (bus.o_we !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL clr_end: got we=%0b busy=%0b expected 0 0", bus.o_we, bus.o_busy); end
    checks++; if (bus.o_ready !== 1'b1 || bus.o_cursor !== 11'd0) begin errors++; $display("[TB] FAIL clr_home: got ready=%0b cursor=%0d expected 1 0", bus.o_ready, bus.o_cursor); end
    checks++; if (dut.u_cursor.col !== 11'd0 || dut.u_cursor.row_base !== 11'd0) begin errors++; $display("[TB] FAIL clr_colrow: got col=%0d row_base=%0d expected 0 0", dut.u_cursor.col, dut.u_cursor.row_base); end
  endtask

  task automatic test_clear_abort();
    int extra = 0;
    do_reset();
    send_settle(8'h51);
    send_byte(CHR_FF);
    repeat (99) step();
    checks++; if (bus.o_we !== 1'b1 || bus.o_addr !== 11'd99) begin errors++; $display("[TB] FAIL abort_pre: got we=%0b addr=%0d expected 1 99", bus.o_we, bus.o_addr); end
    i_rst = 1'b1;
    step();
    checks++; if (bus.o_we !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_we: got we=%0b busy=%0b expected 0 0", bus.o_we, bus.o_busy); end
    checks++; if (bus.o_cursor !== 11'd0 || bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_state: got cursor=%0d ready=%0b expected 0 1", bus.o_cursor, bus.o_ready); end
    i_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.o_we !== 1'b0) extra++;
      step();
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL abort_nowrite: got %0d writes expected 0", extra); end
    send_byte(8'h52);
    checks++; if (bus.o_we !== 1'b1 || bus.o_addr !== 11'd0 || bus.o_wdata !== 8'h52) begin errors++; $display("[TB] FAIL abort_resume: got we=%0b addr=%0d data=%0h expected 1 0 52", bus.o_we, bus.o_addr, bus.o_wdata); end
    step();
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    $display("[TB] start");
    test_reset();
    test_back_to_back();
    test_row_wrap();
    test_screen_wrap();
    test_cr_lf_bs();
    test_boundaries();
    test_clear();
    test_clear_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
